// File: rtl/sd_sector_uart_dump_if.sv
// Port bundle for sd_sector_uart_dump: sector byte stream in, UART line and status out.
interface sd_sector_uart_dump_if #(
  parameter int unsigned SECTOR_BYTES = 512
);
  localparam int unsigned CW = $clog2(SECTOR_BYTES) + 1;

  logic [7:0]    data_in;
  logic          data_valid;
  logic          read_done;
  logic          uart_tx;
  logic          busy;
  logic          dump_done;
  logic          overflow;
  logic [CW-1:0] byte_count;

  modport master (
    output data_in, data_valid, read_done,
    input  uart_tx, busy, dump_done, overflow, byte_count
  );

  modport slave (
    input  data_in, data_valid, read_done,
    output uart_tx, busy, dump_done, overflow, byte_count
  );
endinterface

// File: rtl/sd_sector_uart_dump.sv
// Captures one SD sector into a local buffer, then replays it plus an 8-bit additive
// checksum over a UART 8N1 line.
module sd_sector_uart_dump #(
  parameter int unsigned CLK_FREQ     = 50000000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned SECTOR_BYTES = 512
) (
  input logic                 i_sys_clk,
  input logic                 i_rst_n,
  sd_sector_uart_dump_if.slave bus
);
  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned AW           = $clog2(SECTOR_BYTES);
  localparam int unsigned CW           = AW + 1;
  localparam int unsigned TW           = $clog2(CLKS_PER_BIT + 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(SECTOR_BYTES);

  typedef enum logic [1:0] {StIdle, StCapture, StSend, StDone} state_e;

  state_e        r_state, w_state_next;
  logic [CW-1:0] r_byte_count, w_byte_count_next;
  logic [7:0]    r_checksum, w_checksum_next;
  logic          r_overflow, w_overflow_next;
  logic          r_rd_prev, r_rd_armed;
  logic [TW-1:0] r_tick, w_tick_next;
  logic [3:0]    r_bit, w_bit_next;
  logic [CW-1:0] r_frame, w_frame_next;
  logic [7:0]    r_rd_data;
  logic [7:0]    r_mem [SECTOR_BYTES];

  logic          w_rd_rise;
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [AW-1:0] w_raddr;
  logic [CW-1:0] w_frame_inc;
  logic [7:0]    w_frame_byte;
  logic [2:0]    w_bit_sel;
  logic          w_tx;

  // A level held high out of reset is not an edge until it has been seen low once.
  assign w_rd_rise   = bus.read_done & ~r_rd_prev & r_rd_armed;
  assign w_waddr     = r_byte_count[AW-1:0];
  assign w_frame_inc = r_frame + CW'(1);
  // Prefetch the next frame's byte during the stop bit so it is ready at the start bit.
  assign w_raddr     = (r_state == StSend && r_bit == 4'd9) ? w_frame_inc[AW-1:0]
                                                              : r_frame[AW-1:0];
  assign w_frame_byte = (r_frame == r_byte_count) ? r_checksum : r_rd_data;
  assign w_bit_sel    = r_bit[2:0] - 3'd1;

  always_comb begin
    w_state_next      = r_state;
    w_byte_count_next = r_byte_count;
    w_checksum_next   = r_checksum;
    w_overflow_next   = r_overflow;
    w_tick_next       = r_tick;
    w_bit_next        = r_bit;
    w_frame_next      = r_frame;
    w_we              = 1'b0;
    unique case (r_state)
      StIdle, StCapture: begin
        if (bus.data_valid) begin
          if (r_byte_count == COUNT_FULL) begin
            w_overflow_next = 1'b1;
          end else begin
            w_we              = 1'b1;
            w_byte_count_next = r_byte_count + CW'(1);
            w_checksum_next   = r_checksum + bus.data_in;
          end
          if (r_state == StIdle) w_state_next = StCapture;
        end
        if (w_rd_rise) w_state_next = StSend;
      end
      StSend: begin
        if (bus.data_valid) w_overflow_next = 1'b1;
        if (r_tick == TICK_LAST) begin
          w_tick_next = '0;
          if (r_bit == 4'd9) begin
            w_bit_next = '0;
            if (r_frame == r_byte_count) w_state_next = StDone;
            else                         w_frame_next = w_frame_inc;
          end else begin
            w_bit_next = r_bit + 4'd1;
          end
        end else begin
          w_tick_next = r_tick + TW'(1);
        end
      end
      StDone: ;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_byte_count <= '0;
      r_checksum   <= '0;
      r_overflow   <= 1'b0;
      r_rd_prev    <= 1'b0;
      r_rd_armed   <= 1'b0;
      r_tick       <= '0;
      r_bit        <= '0;
      r_frame      <= '0;
    end else begin
      r_state      <= w_state_next;
      r_byte_count <= w_byte_count_next;
      r_checksum   <= w_checksum_next;
      r_overflow   <= w_overflow_next;
      r_rd_prev    <= bus.read_done;
      r_rd_armed   <= r_rd_armed | ~bus.read_done;
      r_tick       <= w_tick_next;
      r_bit        <= w_bit_next;
      r_frame      <= w_frame_next;
    end
  end

  // Sector buffer: contents survive reset.
  always_ff @(posedge i_sys_clk) begin
    if (w_we) r_mem[w_waddr] <= bus.data_in;
    r_rd_data <= r_mem[w_raddr];
  end

  // Decoded from registered state only, so reset forces the line high asynchronously.
  always_comb begin
    w_tx = 1'b1;
    if (r_state == StSend) begin
      if (r_bit == 4'd0)      w_tx = 1'b0;
      else if (r_bit <= 4'd8) w_tx = w_frame_byte[w_bit_sel];
    end
  end

  assign bus.uart_tx    = w_tx;
  assign bus.busy       = (r_state == StCapture) || (r_state == StSend);
  assign bus.dump_done  = (r_state == StDone);
  assign bus.overflow   = r_overflow;
  assign bus.byte_count = r_byte_count;
endmodule
